sha3_req_arbiter: RTL and testbench
===================================

# sha3_req_arbiter

Round-robin arbiter and transaction sequencer that shares one SHA3/SHAKE core and its 64-bit output serializer among up to four requesters (matrix-A expansion, noise sampling, seed hashing). It grants one requester at a time and launches the core in that requester's mode. It then counts the 64-bit output words the core returns for that mode and routes them to the granted requester. It closes the transaction after the last word. It sits between the Frodo sampling/keygen controllers and the SHA3 core.

## Interface
- NREQ, 2, number of requesters; legal 2..4.
- TIMEOUT, 255, maximum idle cycles between core words (used only with SHA3_ARB_TIMEOUT_EN); legal 1..65535.

- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- req_i  in  NREQ  level request per requester.
- req_mode_i  in  3*NREQ  mode per requester; requester k uses bits [3k+2:3k].
- grant_o  out  NREQ  one-hot grant; held for the whole transaction.
- dout_o  out  64  routed output word, shared by all requesters.
- dvalid_o  out  NREQ  per-requester word strobe, one cycle.
- done_o  out  NREQ  per-requester end-of-transaction pulse, one cycle.
- err_o  out  NREQ  per-requester timeout-abort pulse, one cycle.
- core_start_o  out  1  one-cycle launch pulse to the core.
- core_mode_o  out  3  mode to the core; held from START until return to IDLE.
- core_dout_i  in  64  core output word.
- core_valid_i  in  1  qualifies core_dout_i, one word per high cycle.

## Operation
- Word count N per mode: 0→21 (SHAKE128), 1→17 (SHAKE256), 2→8 (SHA3-512), 3→6 (SHA3-384), 4→4 (SHA3-256), 5→4 (SHA3-224), 6/7→8.
- FSM has three states: IDLE, START, WAIT.
- IDLE: when any req_i is high, choose the winner by round robin. Scan starts at pointer ptr and wraps modulo NREQ. Latch the winner index g and req_mode_i[g], then go to START. With no request, stay in IDLE.
- START: core_start_o=1 for exactly one cycle. Clear the word counter wcnt. Go to WAIT.
- WAIT: on each core_valid_i, register core_dout_i into dout_o, pulse dvalid_o[g], and increment wcnt.
- On the word with wcnt==N-1, also pulse done_o[g], set ptr=(g+1) mod NREQ, and go to IDLE.
- Only the granted bit of dvalid_o/done_o/err_o may be high. All other bits are 0.
- core_valid_i outside WAIT is ignored: no dout_o update, no strobe.
- Changes to req_i or req_mode_i after arbitration are ignored. A transaction always runs to completion even if the requester drops req_i.
- Simultaneous requests: the lowest index at or after ptr wins.
- wcnt is 5 bits. No wrap is possible because N≤21.
- Reset (any state, including mid-transaction): state=IDLE, ptr=0, wcnt=0. All outputs are 0: grant_o, dout_o, dvalid_o, done_o, err_o, core_start_o, core_mode_o. Words arriving from the core after reset are ignored.

## Timing
- Requests are sampled in IDLE at cycle t. At t+1, grant_o[g], core_mode_o and core_start_o are valid (START). WAIT begins at t+2.
- A core word accepted at cycle w appears on dout_o/dvalid_o[g] at w+1, giving one cycle of registered latency.
- For the last word at w: done_o[g] and the final dvalid_o[g] both fire at w+1. grant_o and core_mode_o drop to 0 at w+1 (state IDLE).
- The earliest next arbitration samples at w+1, so the next grant appears at w+2.
- Back-to-back words (core_valid_i high on consecutive cycles) are supported with no drop.

## Configuration
- SHA3_ARB_TIMEOUT_EN defined:
  - A 16-bit watchdog counts WAIT cycles without core_valid_i. It reloads on START and on every accepted word.
  - When it reaches TIMEOUT, err_o[g] and done_o[g] pulse together in the next cycle. grant_o drops, ptr advances, and the state returns to IDLE.
  - Words that arrive after the abort are ignored.
- SHA3_ARB_TIMEOUT_EN undefined:
  - No watchdog logic is built, and err_o is tied to 0.
  - WAIT lasts until N words arrive.

## Test plan
- Reset to idle: hold reset_n=0 for 2 cycles with req_i all ones → every output is 0. After release, req_i=2'b01 with mode 4 → grant_o=01 and core_start_o pulse at t+1.
- Single transaction: requester 1, mode 0, core returns 21 words 0x1..0x15 back-to-back → 21 dvalid_o[1] pulses carrying 0x1..0x15 in order. done_o[1] coincides with 0x15, and grant_o=0 the next cycle.
- Round robin: req_i=2'b11 held, mode 4 on both → grants alternate 01,10,01. Each grant gets exactly 4 dvalid pulses and one done_o.
- Mode default and ignored inputs: mode 7 → done after 8 words. core_valid_i in IDLE with data 0xDEAD → no dvalid_o and dout_o unchanged. Dropping req_i mid-WAIT → still 8 words.
- Reset mid-transaction: assert reset_n=0 after 3 of 17 words (mode 1) → all outputs 0. The next request grants requester 0 with a fresh count of 17.
- Timeout (macro on, TIMEOUT=10): core stops after 2 of 6 words (mode 3) → err_o[g] and done_o[g] pulse 11 cycles after the last word, then grant drops. With the macro off, grant is held indefinitely and err_o stays 0.

Source files
------------

// File: rtl/sha3_req_arbiter.sv
// Round-robin arbiter that shares one SHA3/SHAKE core among NREQ requesters and routes its output words.
// Optional idle-word watchdog abort is built when SHA3_ARB_TIMEOUT_EN is defined.
module sha3_req_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req_i,
  input  logic [3*NREQ-1:0]      req_mode_i,
  output logic [NREQ-1:0]        grant_o,
  output logic [63:0]            dout_o,
  output logic [NREQ-1:0]        dvalid_o,
  output logic [NREQ-1:0]        done_o,
  output logic [NREQ-1:0]        err_o,
  output logic                   core_start_o,
  output logic [2:0]             core_mode_o,
  input  logic [63:0]            core_dout_i,
  input  logic                   core_valid_i
);

  localparam int IW = (NREQ > 2) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 4) begin : gBadNreq
    $error("sha3_req_arbiter: NREQ must be 2..4");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : gBadTimeout
    $error("sha3_req_arbiter: TIMEOUT must be 1..65535");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     grantIdx_q, grantIdx_d;
  logic [2:0]        mode_q, mode_d;
  logic [4:0]        wordCnt_q, wordCnt_d;
  logic [63:0]       dout_q, dout_d;
  logic [NREQ-1:0]   dvalid_q, dvalid_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [NREQ-1:0]   grantOneHot;
  logic [IW-1:0]     nextPtr;
  logic [4:0]        lastWord;
  logic [2*NREQ-1:0] reqRotated;
  logic              reqFound;
  int                winIdx;

`ifdef SHA3_ARB_TIMEOUT_EN
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);
  logic [15:0]       wdog_q, wdog_d;
  logic [NREQ-1:0]   err_q, err_d;
`endif

  function automatic logic [4:0] wordsFor(input logic [2:0] mode);
    case (mode)
      3'd0:    wordsFor = 5'd21;
      3'd1:    wordsFor = 5'd17;
      3'd2:    wordsFor = 5'd8;
      3'd3:    wordsFor = 5'd6;
      3'd4:    wordsFor = 5'd4;
      3'd5:    wordsFor = 5'd4;
      default: wordsFor = 5'd8;
    endcase
  endfunction

  assign lastWord = wordsFor(mode_q) - 5'd1;
  assign nextPtr  = (int'(grantIdx_q) == NREQ - 1) ? '0 : grantIdx_q + IW'(1);

  always_comb begin
    grantOneHot = '0;
    for (int k = 0; k < NREQ; k++) begin
      grantOneHot[k] = (int'(grantIdx_q) == k);
    end
  end

  // Rotating the duplicated request vector by ptr puts the search start at bit 0.
  always_comb begin
    reqRotated = {req_i, req_i} >> ptr_q;
    reqFound   = 1'b0;
    winIdx     = 0;
    for (int i = 0; i < NREQ; i++) begin
      if (!reqFound && reqRotated[i]) begin
        reqFound = 1'b1;
        winIdx   = int'(ptr_q) + i;
        if (winIdx >= NREQ) begin
          winIdx = winIdx - NREQ;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      grantIdx_q <= '0;
      mode_q     <= 3'd0;
      wordCnt_q  <= 5'd0;
      dout_q     <= 64'd0;
      dvalid_q   <= '0;
      done_q     <= '0;
`ifdef SHA3_ARB_TIMEOUT_EN
      wdog_q     <= 16'd0;
      err_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grantIdx_q <= grantIdx_d;
      mode_q     <= mode_d;
      wordCnt_q  <= wordCnt_d;
      dout_q     <= dout_d;
      dvalid_q   <= dvalid_d;
      done_q     <= done_d;
`ifdef SHA3_ARB_TIMEOUT_EN
      wdog_q     <= wdog_d;
      err_q      <= err_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grantIdx_d = grantIdx_q;
    mode_d     = mode_q;
    wordCnt_d  = wordCnt_q;
    dout_d     = dout_q;
    dvalid_d   = '0;
    done_d     = '0;
`ifdef SHA3_ARB_TIMEOUT_EN
    wdog_d     = wdog_q;
    err_d      = '0;
`endif
    case (state_q)
      IDLE: begin
        if (reqFound) begin
          grantIdx_d = IW'(winIdx);
          for (int k = 0; k < NREQ; k++) begin
            if (k == winIdx) begin
              mode_d = req_mode_i[3*k +: 3];
            end
          end
          state_d = START;
        end
      end
      START: begin
        wordCnt_d = 5'd0;
`ifdef SHA3_ARB_TIMEOUT_EN
        wdog_d    = 16'd0;
`endif
        state_d   = WAIT;
      end
      WAIT: begin
        if (core_valid_i) begin
          dout_d    = core_dout_i;
          dvalid_d  = grantOneHot;
          wordCnt_d = wordCnt_q + 5'd1;
`ifdef SHA3_ARB_TIMEOUT_EN
          wdog_d    = 16'd0;
`endif
          if (wordCnt_q == lastWord) begin
            done_d  = grantOneHot;
            ptr_d   = nextPtr;
            state_d = IDLE;
          end
`ifdef SHA3_ARB_TIMEOUT_EN
        end else if (wdog_q == TimeoutLast) begin
          // A stalled core aborts the transaction so other requesters are not starved.
          err_d   = grantOneHot;
          done_d  = grantOneHot;
          ptr_d   = nextPtr;
          state_d = IDLE;
        end else begin
          wdog_d = wdog_q + 16'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_o      = (state_q != IDLE) ? grantOneHot : '0;
    core_mode_o  = (state_q != IDLE) ? mode_q : 3'd0;
    core_start_o = (state_q == START);
    dout_o       = dout_q;
    dvalid_o     = dvalid_q;
    done_o       = done_q;
`ifdef SHA3_ARB_TIMEOUT_EN
    err_o        = err_q;
`else
    err_o        = '0;
`endif
  end

endmodule

// File: tb/tb_sha3_req_arbiter.sv
// Self-checking bench for sha3_req_arbiter: table-driven vectors plus hand-written multi-cycle sequences.
// Covers the SHA3_ARB_TIMEOUT_EN abort path when that macro is defined, otherwise the held-grant behaviour.
module tb_sha3_req_arbiter;

  logic        clk;
  logic        reset_n;
  logic [1:0]  req_i;
  logic [5:0]  req_mode_i;
  logic [1:0]  grant_o;
  logic [63:0] dout_o;
  logic [1:0]  dvalid_o;
  logic [1:0]  done_o;
  logic [1:0]  err_o;
  logic        core_start_o;
  logic [2:0]  core_mode_o;
  logic [63:0] core_dout_i;
  logic        core_valid_i;

  int          checks;
  int          failures;
  logic [63:0] lastDout;

  typedef struct {
    logic        rstN;
    logic [1:0]  req;
    logic [5:0]  mode;
    logic        cv;
    logic [63:0] cd;
    logic [1:0]  eGrant;
    logic        eStart;
    logic [2:0]  eMode;
    logic [1:0]  eDvalid;
    logic [1:0]  eDone;
    logic [63:0] eDout;
  } vec_t;

  vec_t vecs[12];

  sha3_req_arbiter #(.NREQ(2), .TIMEOUT(10)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_i        (req_i),
    .req_mode_i   (req_mode_i),
    .grant_o      (grant_o),
    .dout_o       (dout_o),
    .dvalid_o     (dvalid_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .core_start_o (core_start_o),
    .core_mode_o  (core_mode_o),
    .core_dout_i  (core_dout_i),
    .core_valid_i (core_valid_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rstN, input logic [1:0] req, input logic [5:0] mode,
                               input logic cv, input logic [63:0] cd);
    reset_n      = rstN;
    req_i        = req;
    req_mode_i   = mode;
    core_valid_i = cv;
    core_dout_i  = cd;
  endtask

  task automatic checkField(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] eGrant, input logic eStart,
                             input logic [2:0] eMode, input logic [1:0] eDvalid,
                             input logic [1:0] eDone, input logic [1:0] eErr, input logic [63:0] eDout);
    checkField({tag, ".grant"},  64'(grant_o),      64'(eGrant));
    checkField({tag, ".start"},  64'(core_start_o), 64'(eStart));
    checkField({tag, ".mode"},   64'(core_mode_o),  64'(eMode));
    checkField({tag, ".dvalid"}, 64'(dvalid_o),     64'(eDvalid));
    checkField({tag, ".done"},   64'(done_o),       64'(eDone));
    checkField({tag, ".err"},    64'(err_o),        64'(eErr));
    checkField({tag, ".dout"},   dout_o,            eDout);
  endtask

  // Two cycles: arbitration into START, then START into WAIT.
  task automatic expectStart(input string tag, input logic [1:0] g, input logic [2:0] m);
    core_valid_i = 1'b0;
    tick();
    checkOutput({tag, ".start"}, g, 1'b1, m, 2'b00, 2'b00, 2'b00, lastDout);
    tick();
    checkOutput({tag, ".wait"}, g, 1'b0, m, 2'b00, 2'b00, 2'b00, lastDout);
  endtask

  // Feeds back-to-back words firstIdx..firstIdx+n-1 of a total-word transaction.
  task automatic serveTxn(input string tag, input logic [1:0] g, input logic [2:0] m,
                          input int firstIdx, input int n, input int total, input logic [63:0] base);
    for (int i = 0; i < n; i++) begin
      logic isLast;
      isLast       = (firstIdx + i == total - 1);
      core_valid_i = 1'b1;
      core_dout_i  = base + 64'(i);
      tick();
      lastDout = base + 64'(i);
      checkOutput($sformatf("%s.w%0d", tag, firstIdx + i), isLast ? 2'b00 : g, 1'b0,
                  isLast ? 3'd0 : m, g, isLast ? g : 2'b00, 2'b00, lastDout);
    end
    core_valid_i = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    lastDout = 64'd0;
    applyStimulus(1'b0, 2'b11, 6'b100100, 1'b0, 64'd0);

    //           rstN  req    mode       cv    cd          grant  st    md    dv     dn     dout
    vecs[0]  = '{1'b0, 2'b11, 6'b100100, 1'b0, 64'h0,      2'b00, 1'b0, 3'd0, 2'b00, 2'b00, 64'h0};
    vecs[1]  = '{1'b0, 2'b11, 6'b100100, 1'b1, 64'h55,     2'b00, 1'b0, 3'd0, 2'b00, 2'b00, 64'h0};
    vecs[2]  = '{1'b1, 2'b01, 6'b000100, 1'b0, 64'h0,      2'b01, 1'b1, 3'd4, 2'b00, 2'b00, 64'h0};
    vecs[3]  = '{1'b1, 2'b00, 6'b000100, 1'b0, 64'h0,      2'b01, 1'b0, 3'd4, 2'b00, 2'b00, 64'h0};
    vecs[4]  = '{1'b1, 2'b00, 6'b000100, 1'b1, 64'hA1,     2'b01, 1'b0, 3'd4, 2'b01, 2'b00, 64'hA1};
    vecs[5]  = '{1'b1, 2'b00, 6'b000100, 1'b0, 64'hFF,     2'b01, 1'b0, 3'd4, 2'b00, 2'b00, 64'hA1};
    vecs[6]  = '{1'b1, 2'b00, 6'b000100, 1'b1, 64'hB2,     2'b01, 1'b0, 3'd4, 2'b01, 2'b00, 64'hB2};
    vecs[7]  = '{1'b1, 2'b00, 6'b000100, 1'b1, 64'hC3,     2'b01, 1'b0, 3'd4, 2'b01, 2'b00, 64'hC3};
    vecs[8]  = '{1'b1, 2'b00, 6'b000100, 1'b1, 64'hD4,     2'b00, 1'b0, 3'd0, 2'b01, 2'b01, 64'hD4};
    vecs[9]  = '{1'b1, 2'b00, 6'b000100, 1'b1, 64'hDEAD,   2'b00, 1'b0, 3'd0, 2'b00, 2'b00, 64'hD4};
    vecs[10] = '{1'b1, 2'b11, 6'b100100, 1'b0, 64'h0,      2'b10, 1'b1, 3'd4, 2'b00, 2'b00, 64'hD4};
    vecs[11] = '{1'b1, 2'b11, 6'b100100, 1'b0, 64'h0,      2'b10, 1'b0, 3'd4, 2'b00, 2'b00, 64'hD4};

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].rstN, vecs[i].req, vecs[i].mode, vecs[i].cv, vecs[i].cd);
      tick();
      checkOutput($sformatf("vec%0d", i), vecs[i].eGrant, vecs[i].eStart, vecs[i].eMode,
                  vecs[i].eDvalid, vecs[i].eDone, 2'b00, vecs[i].eDout);
    end
    lastDout     = 64'hD4;
    core_valid_i = 1'b0;

    // Round robin with both requests held: 10 (from table), then 01, then 10.
    serveTxn("rr1", 2'b10, 3'd4, 0, 4, 4, 64'h100);
    expectStart("rr2", 2'b01, 3'd4);
    serveTxn("rr2", 2'b01, 3'd4, 0, 4, 4, 64'h200);
    expectStart("rr3", 2'b10, 3'd4);
    req_i = 2'b00;
    serveTxn("rr3", 2'b10, 3'd4, 0, 4, 4, 64'h300);
    tick();
    checkOutput("rrIdle", 2'b00, 1'b0, 3'd0, 2'b00, 2'b00, 2'b00, lastDout);

    // SHAKE128 on requester 1: 21 words 0x1..0x15.
    req_i      = 2'b10;
    req_mode_i = 6'b000000;
    expectStart("single", 2'b10, 3'd0);
    req_i = 2'b00;
    serveTxn("single", 2'b10, 3'd0, 0, 21, 21, 64'h1);
    tick();
    checkOutput("singleIdle", 2'b00, 1'b0, 3'd0, 2'b00, 2'b00, 2'b00, 64'h15);

    // Mode 7 defaults to 8 words; request dropped during WAIT.
    req_i      = 2'b01;
    req_mode_i = 6'b000111;
    expectStart("mode7", 2'b01, 3'd7);
    req_i = 2'b00;
    serveTxn("mode7", 2'b01, 3'd7, 0, 8, 8, 64'h40);
    core_valid_i = 1'b1;
    core_dout_i  = 64'hDEAD;
    tick();
    checkOutput("idleValid", 2'b00, 1'b0, 3'd0, 2'b00, 2'b00, 2'b00, 64'h47);
    core_valid_i = 1'b0;

    // Reset after 3 of 17 words, then a fresh 17-word transaction from ptr=0.
    req_i      = 2'b10;
    req_mode_i = 6'b001000;
    expectStart("rstMid", 2'b10, 3'd1);
    req_i = 2'b00;
    serveTxn("rstMid", 2'b10, 3'd1, 0, 3, 17, 64'h60);
    reset_n      = 1'b0;
    core_valid_i = 1'b1;
    core_dout_i  = 64'h99;
    tick();
    lastDout = 64'd0;
    checkOutput("rstMid.reset", 2'b00, 1'b0, 3'd0, 2'b00, 2'b00, 2'b00, lastDout);
    reset_n    = 1'b1;
    req_i      = 2'b11;
    req_mode_i = 6'b001001;
    expectStart("afterRst", 2'b01, 3'd1);
    req_i = 2'b00;
    serveTxn("afterRst", 2'b01, 3'd1, 0, 17, 17, 64'h700);

    // Core stalls after 2 of 6 words (mode 3).
    req_i      = 2'b01;
    req_mode_i = 6'b000011;
    expectStart("stall", 2'b01, 3'd3);
    req_i = 2'b00;
    serveTxn("stall", 2'b01, 3'd3, 0, 2, 6, 64'h800);
`ifdef SHA3_ARB_TIMEOUT_EN
    for (int k = 0; k < 9; k++) begin
      tick();
      checkOutput($sformatf("toQuiet%0d", k), 2'b01, 1'b0, 3'd3, 2'b00, 2'b00, 2'b00, lastDout);
    end
    tick();
    checkOutput("toAbort", 2'b00, 1'b0, 3'd0, 2'b00, 2'b01, 2'b01, lastDout);
    core_valid_i = 1'b1;
    core_dout_i  = 64'hBAD;
    tick();
    checkOutput("toLate", 2'b00, 1'b0, 3'd0, 2'b00, 2'b00, 2'b00, lastDout);
    core_valid_i = 1'b0;
`else
    for (int k = 0; k < 30; k++) begin
      tick();
      checkOutput($sformatf("hold%0d", k), 2'b01, 1'b0, 3'd3, 2'b00, 2'b00, 2'b00, lastDout);
    end
    serveTxn("stallEnd", 2'b01, 3'd3, 2, 4, 6, 64'h800);
`endif
    tick();
    checkOutput("final", 2'b00, 1'b0, 3'd0, 2'b00, 2'b00, 2'b00, lastDout);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
